// File: rtl/fifo_pkg.sv
// Shared sizing helpers and status bundle type for the parametrised single-clock FIFO.
package fifo_pkg;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return ptr_w(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

   typedef struct packed {
      logic full;
      logic empty;
      logic almost_full;
      logic almost_empty;
      logic overflow;
      logic underflow;
   } fifo_status_t;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port RAM: one write port, one registered read port; storage is never reset.
module fifo_mem_2p
   import fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we,
   input  logic [ptr_w(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic                      re,
   input  logic [ptr_w(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]          rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the output register is reset; it holds its value when no read is accepted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: pointers, occupancy, threshold/error flags and flush control.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      wr,
   input  logic [WIDTH-1:0]          dataIn,
   input  logic                      rd,
   output logic [WIDTH-1:0]          dataOut,
   output logic                      data_valid,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

   generate
      if (!is_pow2(DEPTH) || DEPTH < 4)
         $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 and >= 4");
      if (AF_LEVEL < 1 || AF_LEVEL > DEPTH)
         $fatal(1, "sync_fifo_param: AF_LEVEL out of range 1..DEPTH");
      if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1)
         $fatal(1, "sync_fifo_param: AE_LEVEL out of range 0..DEPTH-1");
      if (WIDTH < 1)
         $fatal(1, "sync_fifo_param: WIDTH must be >= 1");
   endgenerate

   logic [PTR_W-1:0] wrptr, rdptr;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q, unf_q, dv_q;
   logic             rd_acc, wr_acc;
   fifo_status_t     st;

   always_comb begin
      st              = '0;
      st.full         = (cnt_q == DEPTH_C);
      st.empty        = (cnt_q == '0);
      st.almost_full  = (cnt_q >= AF_C);
      st.almost_empty = (cnt_q <= AE_C);
      st.overflow     = ovf_q;
      st.underflow    = unf_q;
   end

   // A read frees a slot in the same edge, so a full FIFO still accepts a write alongside it.
   always_comb begin
      rd_acc = rd & ~st.empty & ~clr;
      wr_acc = wr & (~st.full | rd_acc) & ~clr;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrptr <= '0;
         rdptr <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         dv_q  <= 1'b0;
      end else if (clr) begin
         wrptr <= '0;
         rdptr <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         dv_q  <= 1'b0;
      end else begin
         if (wr_acc) wrptr <= wrptr + PTR_W'(1);
         if (rd_acc) rdptr <= rdptr + PTR_W'(1);
         case ({wr_acc, rd_acc})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (wr & st.full & ~rd) ovf_q <= 1'b1;
         if (rd & st.empty)      unf_q <= 1'b1;
         dv_q <= rd_acc;
      end
   end

   fifo_mem_2p #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_acc),
      .waddr (wrptr),
      .wdata (dataIn),
      .re    (rd_acc),
      .raddr (rdptr),
      .rdata (dataOut)
   );

   assign data_valid   = dv_q;
   assign count        = cnt_q;
   assign full         = st.full;
   assign empty        = st.empty;
   assign almost_full  = st.almost_full;
   assign almost_empty = st.almost_empty;
   assign overflow     = st.overflow;
   assign underflow    = st.underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=16, AF=14, AE=2).
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst_n, clr, wr, rd;
   logic [7:0] dataIn, dataOut;
   logic       data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sync_fifo_param #(
      .WIDTH    (8),
      .DEPTH    (16),
      .AF_LEVEL (14),
      .AE_LEVEL (2)
   ) dut (
      .clk          (clk),
      .rst          (rst_n),
      .clr          (clr),
      .wr           (wr),
      .dataIn       (dataIn),
      .rd           (rd),
      .dataOut      (dataOut),
      .data_valid   (data_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   task automatic cyc(input logic w, input logic [7:0] d, input logic r);
      wr = w; dataIn = d; rd = r;
      @(posedge clk); #1;
      wr = 1'b0; rd = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; dataIn = '0;
      #12;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL reset_dataOut got=%h exp=00", dataOut); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_dv got=%b exp=0", data_valid); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b exp=0", almost_full); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {overflow, underflow}); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_order();
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL order_count_full got=%0d exp=16", count); end
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL order_full got=%b exp=1", full); end
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 8'h00, 1'b1);
         checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL order_dv[%0d] got=%b exp=1", i, data_valid); end
         checks++; if (dataOut !== 8'(i)) begin errors++; $display("FAIL order_data[%0d] got=%h exp=%h", i, dataOut, 8'(i)); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL order_empty got=%b exp=1", empty); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL order_count got=%0d exp=0", count); end
      cyc(1'b0, 8'h00, 1'b0);
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL order_dv_idle got=%b exp=0", data_valid); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'h10 + 8'(i), 1'b0);
      cyc(1'b1, 8'hAA, 1'b0);
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 8'h00, 1'b1);
         checks++; if (dataOut !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_drain[%0d] got=%h exp=%h", i, dataOut, 8'h10 + 8'(i)); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b exp=1", empty); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
      do_clr();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'h20 + 8'(i), 1'b0);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 8'h55, 1'b1);
         checks++; if (count !== 5'd16) begin errors++; $display("FAIL frw_count[%0d] got=%0d exp=16", k, count); end
         checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL frw_ovf[%0d] got=%b exp=0", k, overflow); end
         checks++; if (dataOut !== 8'h20 + 8'(k)) begin errors++; $display("FAIL frw_data[%0d] got=%h exp=%h", k, dataOut, 8'h20 + 8'(k)); end
      end
      for (int i = 0; i < 16; i++) begin
         logic [7:0] exp_d;
         exp_d = (i < 12) ? 8'h24 + 8'(i) : 8'h55;
         cyc(1'b0, 8'h00, 1'b1);
         checks++; if (dataOut !== exp_d) begin errors++; $display("FAIL frw_drain[%0d] got=%h exp=%h", i, dataOut, exp_d); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL frw_empty got=%b exp=1", empty); end
   endtask

   task automatic test_empty_rw();
      cyc(1'b1, 8'h33, 1'b1);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL erw_unf got=%b exp=1", underflow); end
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL erw_count got=%0d exp=1", count); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL erw_dv got=%b exp=0", data_valid); end
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (dataOut !== 8'h33) begin errors++; $display("FAIL erw_data got=%h exp=33", dataOut); end
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL erw_dv2 got=%b exp=1", data_valid); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL erw_empty got=%b exp=1", empty); end
      do_clr();
   endtask

   task automatic test_thresholds_wrap();
      logic [7:0] q[$];
      logic [7:0] exp_d;
      int n = 0;
      for (int i = 0; i < 14; i++) begin
         cyc(1'b1, 8'h60 + 8'(i), 1'b0);
         q.push_back(8'h60 + 8'(i)); n++;
         checks++; if (almost_full !== (n >= 14)) begin errors++; $display("FAIL thr_af[n=%0d] got=%b exp=%b", n, almost_full, (n >= 14)); end
         checks++; if (almost_empty !== (n <= 2)) begin errors++; $display("FAIL thr_ae_w[n=%0d] got=%b exp=%b", n, almost_empty, (n <= 2)); end
      end
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, 8'h00, 1'b1);
         exp_d = q.pop_front(); n--;
         checks++; if (dataOut !== exp_d) begin errors++; $display("FAIL thr_rd[%0d] got=%h exp=%h", i, dataOut, exp_d); end
         checks++; if (almost_empty !== (n <= 2)) begin errors++; $display("FAIL thr_ae_r[n=%0d] got=%b exp=%b", n, almost_empty, (n <= 2)); end
      end
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 8'h80 + 8'(i), 1'b1);
         exp_d = q.pop_front();
         q.push_back(8'h80 + 8'(i));
         checks++; if (dataOut !== exp_d) begin errors++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, dataOut, exp_d); end
         checks++; if (count !== 5'd2) begin errors++; $display("FAIL wrap_count[%0d] got=%0d exp=2", i, count); end
      end
      do_clr();
   endtask

   task automatic test_async_reset_and_clr();
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'h71 + 8'(i), 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (dataOut !== 8'h71) begin errors++; $display("FAIL ar_pre_data got=%h exp=71", dataOut); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ar_empty got=%b exp=1", empty); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", count); end
      checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL ar_dataOut got=%h exp=00", dataOut); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ar_dv got=%b exp=0", data_valid); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      cyc(1'b1, 8'h99, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (dataOut !== 8'h99) begin errors++; $display("FAIL ar_post_data got=%h exp=99", dataOut); end
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL cl_unf_set got=%b exp=1", underflow); end
      checks++; if (dataOut !== 8'h99) begin errors++; $display("FAIL cl_hold_unf got=%h exp=99", dataOut); end
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0);
      checks++; if (count !== 5'd8) begin errors++; $display("FAIL cl_pre_count got=%0d exp=8", count); end
      clr = 1'b1; wr = 1'b1; rd = 1'b1; dataIn = 8'hEE;
      @(posedge clk); #1;
      clr = 1'b0; wr = 1'b0; rd = 1'b0;
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL cl_count got=%0d exp=0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL cl_empty got=%b exp=1", empty); end
      checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL cl_flags got=%b exp=00", {overflow, underflow}); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL cl_dv got=%b exp=0", data_valid); end
      checks++; if (dataOut !== 8'h99) begin errors++; $display("FAIL cl_hold got=%h exp=99", dataOut); end
      cyc(1'b1, 8'h5A, 1'b0);
      cyc(1'b0, 8'h00, 1'b1);
      checks++; if (dataOut !== 8'h5A) begin errors++; $display("FAIL cl_after got=%h exp=5a", dataOut); end
   endtask

   initial begin
      test_reset();
      test_order();
      test_overflow();
      test_full_rw();
      test_empty_rw();
      test_thresholds_wrap();
      test_async_reset_and_clr();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
